// File: rtl/intercon_slave_decoder.sv
// -----------------------------------------------------------------------------
// intercon_slave_decoder
//   Slave-side end of the i2d SoC intercon. Takes the bus cycle of the master
//   currently granted by the arbiter, decodes the top DEC_BITS of the address
//   to one of SLAVE_NUM slaves, and forwards strobe/cycle to that slave only.
//   It returns that slave's ack/err/read data to the master. Unmapped addresses
//   and slaves that stay silent for TIMEOUT cycles produce a one-cycle bus error.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   m_cyc, m_stb, m_we       granted master cycle / strobe / write enable
//   m_adr, m_sel, m_dat_i    granted master address / byte selects / write data
//   m_dat_o, m_ack, m_err    read data, acknowledge and error back to the master
//   s_cyc, s_stb             per-slave cycle and strobe (at most one bit set)
//   s_we, s_adr, s_sel,      broadcast copies of the master signals
//   s_dat_o
//   s_dat_i                  packed slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_ack, s_err             per-slave acknowledge and error
// -----------------------------------------------------------------------------
module intercon_slave_decoder #(
    parameter int SLAVE_NUM  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEC_BITS   = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            m_cyc,
    input  logic                            m_stb,
    input  logic                            m_we,
    input  logic [ADDR_WIDTH-1:0]           m_adr,
    input  logic [DATA_WIDTH/8-1:0]         m_sel,
    input  logic [DATA_WIDTH-1:0]           m_dat_i,
    output logic [DATA_WIDTH-1:0]           m_dat_o,
    output logic                            m_ack,
    output logic                            m_err,
    output logic [SLAVE_NUM-1:0]            s_cyc,
    output logic [SLAVE_NUM-1:0]            s_stb,
    output logic                            s_we,
    output logic [ADDR_WIDTH-1:0]           s_adr,
    output logic [DATA_WIDTH/8-1:0]         s_sel,
    output logic [DATA_WIDTH-1:0]           s_dat_o,
    input  logic [SLAVE_NUM*DATA_WIDTH-1:0] s_dat_i,
    input  logic [SLAVE_NUM-1:0]            s_ack,
    input  logic [SLAVE_NUM-1:0]            s_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERR    = 2'd2
    } state_t;

    state_t                state, next_state;
    logic [DEC_BITS-1:0]   sel_q;
    logic [15:0]           wdog;

    logic [DEC_BITS-1:0]   dec_idx;
    logic                  dec_hit;
    logic [SLAVE_NUM-1:0]  sel_onehot;
    logic                  sel_ack;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic                  wdog_expired;

    // Write-side signals go to every slave; only s_cyc/s_stb qualify them.
    assign s_we    = m_we;
    assign s_adr   = m_adr;
    assign s_sel   = m_sel;
    assign s_dat_o = m_dat_i;

    assign dec_idx      = m_adr[ADDR_WIDTH-1 -: DEC_BITS];
    assign dec_hit      = ({{(32-DEC_BITS){1'b0}}, dec_idx} < 32'(SLAVE_NUM));
    assign wdog_expired = (wdog == 16'(TIMEOUT));

    // Mux the registered slave index onto the per-slave response vectors.
    // A loop keeps sel_q free of out-of-range indexing when SLAVE_NUM < 2**DEC_BITS.
    always_comb begin
        sel_onehot = '0;
        sel_ack    = 1'b0;
        sel_err    = 1'b0;
        sel_dat    = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (sel_q == DEC_BITS'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_ack       = s_ack[i];
                sel_err       = s_err[i];
                sel_dat       = s_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        next_state = state;
        s_cyc      = '0;
        s_stb      = '0;
        m_ack      = 1'b0;
        m_err      = 1'b0;
        m_dat_o    = '0;
        case (state)
            IDLE: begin
                if (m_cyc && m_stb) begin
                    next_state = dec_hit ? ACTIVE : ERR;
                end
            end
            ACTIVE: begin
                if (!m_cyc) begin
                    // Master abort: release the slave this cycle, report nothing.
                    next_state = IDLE;
                end else begin
                    s_cyc = sel_onehot;
                    s_stb = m_stb ? sel_onehot : '0;
                    if (sel_ack) begin
                        // Ack outranks both a simultaneous err and the watchdog.
                        m_ack      = 1'b1;
                        m_dat_o    = sel_dat;
                        next_state = IDLE;
                    end else if (sel_err) begin
                        m_err      = 1'b1;
                        next_state = IDLE;
                    end else if (wdog_expired) begin
                        next_state = ERR;
                    end
                end
            end
            ERR: begin
                m_err      = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sel_q <= '0;
            wdog  <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                // Watchdog restarts from zero for every transfer, including after an abort.
                wdog <= '0;
                if (m_cyc && m_stb && dec_hit) begin
                    sel_q <= dec_idx;
                end
            end else if (state == ACTIVE) begin
                wdog <= wdog + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_intercon_slave_decoder.sv
// -----------------------------------------------------------------------------
// tb_intercon_slave_decoder
//   Directed bench for intercon_slave_decoder with SLAVE_NUM=4, TIMEOUT=8.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on the
//   falling edge. Cycle 0 of a transfer is the IDLE decode cycle.
// -----------------------------------------------------------------------------
module tb_intercon_slave_decoder;

    localparam int SN = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             m_cyc, m_stb, m_we;
    logic [AW-1:0]    m_adr;
    logic [DW/8-1:0]  m_sel;
    logic [DW-1:0]    m_dat_i;
    logic [DW-1:0]    m_dat_o;
    logic             m_ack, m_err;
    logic [SN-1:0]    s_cyc, s_stb;
    logic             s_we;
    logic [AW-1:0]    s_adr;
    logic [DW/8-1:0]  s_sel;
    logic [DW-1:0]    s_dat_o;
    logic [SN*DW-1:0] s_dat_i;
    logic [SN-1:0]    s_ack, s_err;

    int n_vec  = 0;
    int n_miss = 0;

    intercon_slave_decoder #(
        .SLAVE_NUM (SN),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEC_BITS  (4),
        .TIMEOUT   (TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_cyc  (m_cyc),
        .m_stb  (m_stb),
        .m_we   (m_we),
        .m_adr  (m_adr),
        .m_sel  (m_sel),
        .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o),
        .m_ack  (m_ack),
        .m_err  (m_err),
        .s_cyc  (s_cyc),
        .s_stb  (s_stb),
        .s_we   (s_we),
        .s_adr  (s_adr),
        .s_sel  (s_sel),
        .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i),
        .s_ack  (s_ack),
        .s_err  (s_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        m_we    = 1'b0;
        m_adr   = '0;
        m_sel   = '0;
        m_dat_i = '0;
        s_ack   = '0;
        s_err   = '0;
        // Distinct data on every slave so a wrong mux selection shows up.
        s_dat_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0001};
    endtask

    task automatic start(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat);
        m_cyc   = 1'b1;
        m_stb   = 1'b1;
        m_we    = we;
        m_adr   = adr;
        m_sel   = 4'hF;
        m_dat_i = dat;
    endtask

    task automatic quiet(input string tag);
        check({tag, "_stb"}, 64'(s_stb), 64'h0);
        check({tag, "_ack"}, 64'(m_ack), 64'h0);
        check({tag, "_err"}, 64'(m_err), 64'h0);
    endtask

    initial begin
        rst = 1'b0;
        bus_idle();

        // Reset state
        settle();
        check("rst_cyc",  64'(s_cyc),   64'h0);
        check("rst_stb",  64'(s_stb),   64'h0);
        check("rst_ack",  64'(m_ack),   64'h0);
        check("rst_err",  64'(m_err),   64'h0);
        check("rst_dat",  64'(m_dat_o), 64'h0);
        next_cyc();
        rst = 1'b1;
        next_cyc();

        // 1: read from slave 2, ack 3 cycles after its first strobe
        start(32'h2000_0010, 1'b0, '0);
        settle();
        check("rd_dec_stb", 64'(s_stb), 64'h0);
        check("rd_adr",     64'(s_adr), 64'h2000_0010);
        next_cyc();
        for (int c = 1; c <= 3; c++) begin
            settle();
            check("rd_wait_stb", 64'(s_stb), 64'b0100);
            check("rd_wait_cyc", 64'(s_cyc), 64'b0100);
            check("rd_wait_ack", 64'(m_ack), 64'h0);
            next_cyc();
        end
        s_ack = 4'b0100;
        s_dat_i[2*DW +: DW] = 32'hDEAD_BEEF;
        settle();
        check("rd_ack",  64'(m_ack),   64'h1);
        check("rd_data", 64'(m_dat_o), 64'hDEAD_BEEF);
        check("rd_err",  64'(m_err),   64'h0);
        next_cyc();
        bus_idle();
        settle();
        quiet("rd_after");
        check("rd_after_dat", 64'(m_dat_o), 64'h0);
        next_cyc();

        // 2: unmapped address (index 5)
        start(32'h5000_0000, 1'b0, '0);
        settle();
        quiet("um_dec");
        next_cyc();
        bus_idle();
        settle();
        check("um_err",  64'(m_err), 64'h1);
        check("um_ack",  64'(m_ack), 64'h0);
        check("um_stb",  64'(s_stb), 64'h0);
        next_cyc();
        settle();
        check("um_err_gone", 64'(m_err), 64'h0);
        next_cyc();

        // 3: watchdog on slave 1, strobe held for TIMEOUT+1 cycles
        start(32'h1000_0000, 1'b0, '0);
        next_cyc();
        for (int c = 1; c <= TO + 1; c++) begin
            settle();
            check("wd_stb", 64'(s_stb), 64'b0010);
            check("wd_err", 64'(m_err), 64'h0);
            next_cyc();
        end
        bus_idle();
        settle();
        check("wd_err_pulse", 64'(m_err), 64'h1);
        check("wd_stb_off",   64'(s_stb), 64'h0);
        check("wd_ack",       64'(m_ack), 64'h0);
        next_cyc();
        settle();
        check("wd_err_end", 64'(m_err), 64'h0);
        next_cyc();

        // 4: master abort 2 cycles into ACTIVE, late ack ignored
        start(32'h1000_0000, 1'b0, '0);
        next_cyc();
        for (int c = 1; c <= 2; c++) begin
            settle();
            check("ab_stb", 64'(s_stb), 64'b0010);
            next_cyc();
        end
        m_cyc = 1'b0;
        m_stb = 1'b0;
        settle();
        check("ab_cyc_drop", 64'(s_cyc), 64'h0);
        quiet("ab_drop");
        next_cyc();
        s_ack = 4'b0010;
        settle();
        quiet("ab_late");
        next_cyc();
        bus_idle();
        next_cyc();

        // 5a: foreign slave responses ignored, ack beats err on the selected slave
        start(32'h3000_0000, 1'b0, '0);
        next_cyc();
        s_ack = 4'b0001;
        s_err = 4'b0001;
        settle();
        check("pr_stb",         64'(s_stb), 64'b1000);
        check("pr_foreign_ack", 64'(m_ack), 64'h0);
        check("pr_foreign_err", 64'(m_err), 64'h0);
        next_cyc();
        s_ack = 4'b1000;
        s_err = 4'b1000;
        settle();
        check("pr_both_ack", 64'(m_ack),   64'h1);
        check("pr_both_err", 64'(m_err),   64'h0);
        check("pr_both_dat", 64'(m_dat_o), 64'h3333_3333);
        next_cyc();
        bus_idle();
        settle();
        quiet("pr_after");
        next_cyc();

        // 5b: ack exactly when the watchdog reaches TIMEOUT
        start(32'h0000_0000, 1'b0, '0);
        next_cyc();
        for (int c = 1; c <= TO; c++) begin
            next_cyc();
        end
        s_ack = 4'b0001;
        settle();
        check("to_ack",     64'(m_ack),   64'h1);
        check("to_ack_err", 64'(m_err),   64'h0);
        check("to_ack_dat", 64'(m_dat_o), 64'h0000_0001);
        next_cyc();
        bus_idle();
        settle();
        check("to_no_err", 64'(m_err), 64'h0);
        next_cyc();

        // 5c: slave error passes through combinationally
        start(32'h2000_0000, 1'b0, '0);
        next_cyc();
        s_err = 4'b0100;
        settle();
        check("se_err", 64'(m_err), 64'h1);
        check("se_ack", 64'(m_ack), 64'h0);
        next_cyc();
        bus_idle();
        settle();
        check("se_err_end", 64'(m_err), 64'h0);
        next_cyc();

        // 6: asynchronous reset mid-transfer, then a clean write to slave 1
        start(32'h1000_0000, 1'b1, 32'hAAAA_5555);
        next_cyc();
        settle();
        check("rs_pre_stb", 64'(s_stb), 64'b0010);
        #1;
        rst = 1'b0;
        #1;
        check("rs_cyc", 64'(s_cyc),   64'h0);
        check("rs_dat", 64'(m_dat_o), 64'h0);
        quiet("rs_mid");
        next_cyc();
        bus_idle();
        next_cyc();
        rst = 1'b1;
        next_cyc();
        start(32'h1000_0000, 1'b1, 32'h1234_5678);
        next_cyc();
        settle();
        check("wr_stb", 64'(s_stb),   64'b0010);
        check("wr_we",  64'(s_we),    64'h1);
        check("wr_adr", 64'(s_adr),   64'h1000_0000);
        check("wr_dat", 64'(s_dat_o), 64'h1234_5678);
        check("wr_sel", 64'(s_sel),   64'hF);
        next_cyc();
        s_ack = 4'b0010;
        settle();
        check("wr_ack", 64'(m_ack), 64'h1);
        check("wr_err", 64'(m_err), 64'h0);
        next_cyc();
        bus_idle();
        next_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
